// File: rtl/serial_comparator.sv
// -----------------------------------------------------------------------------
// serial_comparator
//
// Bit-serial, MSB-first unsigned magnitude comparator with a start/done
// handshake. A and B are captured when a start is accepted and then one bit
// pair is examined per clock. The result comes out as registered, one-hot
// GREATER / EQUAL / SMALLER flags, updated on the same edge that raises done.
//
// Parameters
//   WIDTH       operand width in bits (>= 2)
//   EARLY_EXIT  1: stop at the first differing bit
//               0: always scan all WIDTH bits; the first difference is
//                  remembered and decides the result
//
// Ports
//   clk      in   1      single clock, rising edge
//   rst      in   1      synchronous, active-high reset
//   start    in   1      compare request, honoured in IDLE and DONE only
//   A        in   WIDTH  operand A (unsigned), captured on an accepted start
//   B        in   WIDTH  operand B (unsigned), captured on an accepted start
//   busy     out  1      high while a comparison is in progress (SHIFT)
//   done     out  1      one-cycle pulse; the flags are valid from this cycle
//   GREATER  out  1      A > B, held until the next done
//   EQUAL    out  1      A == B, held until the next done
//   SMALLER  out  1      A < B, held until the next done
// -----------------------------------------------------------------------------
module serial_comparator #(
    parameter int WIDTH      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             GREATER,
    output logic             EQUAL,
    output logic             SMALLER
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Operand shift registers: the bit under test is always the MSB.
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] a_shl;
    logic [WIDTH-1:0] b_shl;

    // Counts the bit pairs still to be examined after the current one.
    logic [CW-1:0]    cnt_reg;

    // Sticky record of the first difference seen (used when EARLY_EXIT=0).
    logic             diff_found_reg;
    logic             diff_gt_reg;

    // Result flags.
    logic             gt_reg;
    logic             eq_reg;
    logic             lt_reg;

    logic             a_msb;
    logic             b_msb;
    logic             bit_diff;
    logic             last_bit;
    logic             accept;
    logic             finish;
    logic             dec_found;
    logic             dec_gt;

    // -------------------------------------------------------------------------
    // Left-shift networks (LSB is filled with zero; its value never matters
    // because the counter ends the scan before it reaches the MSB).
    // -------------------------------------------------------------------------
    assign a_shl[0] = 1'b0;
    assign b_shl[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign a_shl[gi] = a_sh_reg[gi-1];
            assign b_shl[gi] = b_sh_reg[gi-1];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Per-cycle evaluation of the current bit pair
    // -------------------------------------------------------------------------
    assign a_msb    = a_sh_reg[WIDTH-1];
    assign b_msb    = b_sh_reg[WIDTH-1];
    assign bit_diff = a_msb ^ b_msb;
    assign last_bit = (cnt_reg == '0);

    // A start is only honoured when no comparison is running.
    assign accept   = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

    // The comparison ends this edge either on the first difference (early
    // exit) or once the last bit pair has been examined.
    assign finish   = (state_reg == ST_SHIFT) &&
                      ((EARLY_EXIT && bit_diff) || last_bit);

    // Final decision: an earlier recorded difference has priority over the
    // bit pair under test, so only the first difference counts.
    assign dec_found = diff_found_reg | bit_diff;
    assign dec_gt    = diff_found_reg ? diff_gt_reg : a_msb;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (finish) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // Back-to-back compare: go straight to SHIFT without an
                // IDLE bubble.
                if (start) begin
                    state_next = ST_SHIFT;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs (Moore, decoded from the state register)
    // -------------------------------------------------------------------------
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state_reg)
            ST_SHIFT: busy = 1'b1;
            ST_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath: operand shift registers, bit counter, sticky difference
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_reg       <= '0;
            b_sh_reg       <= '0;
            cnt_reg        <= '0;
            diff_found_reg <= 1'b0;
            diff_gt_reg    <= 1'b0;
        end else if (accept) begin
            a_sh_reg       <= A;
            b_sh_reg       <= B;
            cnt_reg        <= CW'(WIDTH - 1);
            diff_found_reg <= 1'b0;
            diff_gt_reg    <= 1'b0;
        end else if (state_reg == ST_SHIFT) begin
            a_sh_reg <= a_shl;
            b_sh_reg <= b_shl;
            if (!last_bit) begin
                cnt_reg <= cnt_reg - CW'(1);
            end
            if (bit_diff && !diff_found_reg) begin
                diff_found_reg <= 1'b1;
                diff_gt_reg    <= a_msb;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Result flags: written only on the edge entering DONE, so they are not
    // disturbed by a new start and stay valid until the next done.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            gt_reg <= 1'b0;
            eq_reg <= 1'b0;
            lt_reg <= 1'b0;
        end else if (finish) begin
            gt_reg <= dec_found &  dec_gt;
            eq_reg <= ~dec_found;
            lt_reg <= dec_found & ~dec_gt;
        end
    end

    assign GREATER = gt_reg;
    assign EQUAL   = eq_reg;
    assign SMALLER = lt_reg;

endmodule

// File: tb/tb_serial_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_comparator
//
// Directed bench for serial_comparator with WIDTH=4. Two instances share the
// clock, reset and operands: u_dut_ee uses EARLY_EXIT=1, u_dut_full uses
// EARLY_EXIT=0. Each has its own start. Cycle 0 is the cycle in which start
// is driven; outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_serial_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_ee;
    logic       start_full;
    logic [3:0] A;
    logic [3:0] B;

    logic busy_ee,   done_ee,   gt_ee,   eq_ee,   lt_ee;
    logic busy_full, done_full, gt_full, eq_full, lt_full;

    int checks   = 0;
    int failures = 0;

    // Last flag value each instance should be holding ({G,E,S}).
    logic [2:0] prev_flags [2];

    always #5 clk = ~clk;

    serial_comparator #(.WIDTH(4), .EARLY_EXIT(1'b1)) u_dut_ee (
        .clk     (clk),
        .rst     (rst),
        .start   (start_ee),
        .A       (A),
        .B       (B),
        .busy    (busy_ee),
        .done    (done_ee),
        .GREATER (gt_ee),
        .EQUAL   (eq_ee),
        .SMALLER (lt_ee)
    );

    serial_comparator #(.WIDTH(4), .EARLY_EXIT(1'b0)) u_dut_full (
        .clk     (clk),
        .rst     (rst),
        .start   (start_full),
        .A       (A),
        .B       (B),
        .busy    (busy_full),
        .done    (done_full),
        .GREATER (gt_full),
        .EQUAL   (eq_full),
        .SMALLER (lt_full)
    );

    // {busy, done, GREATER, EQUAL, SMALLER}
    function automatic logic [4:0] obs(input int sel);
        if (sel == 0) return {busy_ee, done_ee, gt_ee, eq_ee, lt_ee};
        return {busy_full, done_full, gt_full, eq_full, lt_full};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_ee = v;
        else          start_full = v;
    endtask

    // One compare with start pulsed in cycle 0; checks busy/done every cycle
    // up to dc+2, flags held before done and equal to fl from done onwards.
    task automatic run_compare(input int sel, input logic [3:0] a, input logic [3:0] b,
                               input int dc, input logic [2:0] fl, input string tag);
        logic [4:0] o;
        A = a;
        B = b;
        set_start(sel, 1'b1);
        step();
        set_start(sel, 1'b0);
        for (int k = 1; k <= dc + 2; k++) begin
            o = obs(sel);
            check($sformatf("%s_busy_c%0d", tag, k), 32'(o[4]), 32'(k < dc));
            check($sformatf("%s_done_c%0d", tag, k), 32'(o[3]), 32'(k == dc));
            if (k >= dc)
                check($sformatf("%s_flags_c%0d", tag, k), 32'(o[2:0]), 32'(fl));
            else
                check($sformatf("%s_hold_c%0d", tag, k), 32'(o[2:0]), 32'(prev_flags[sel]));
            step();
        end
        prev_flags[sel] = fl;
        $display("txn %s sel=%0d A=%b B=%b done_cycle=%0d flags=%b", tag, sel, a, b, dc, fl);
    endtask

    initial begin
        logic [4:0] o;
        int         ndone;

        rst           = 1'b1;
        start_ee      = 1'b0;
        start_full    = 1'b0;
        A             = '0;
        B             = '0;
        prev_flags[0] = 3'b000;
        prev_flags[1] = 3'b000;

        // ---------------- reset ----------------
        step();
        step();
        check("rst_ee_in",   32'(obs(0)), 32'h0);
        check("rst_full_in", 32'(obs(1)), 32'h0);
        rst = 1'b0;
        step();
        check("rst_ee_out",   32'(obs(0)), 32'h0);
        check("rst_full_out", 32'(obs(1)), 32'h0);
        $display("txn reset outputs idle");

        // ---------------- early-exit instance ----------------
        run_compare(0, 4'b1010, 4'b0110, 2, 3'b100, "t1_gt_msb");
        run_compare(0, 4'b0101, 4'b0101, 5, 3'b010, "t2_eq");
        run_compare(0, 4'b0010, 4'b0011, 5, 3'b001, "t3_lt_lsb");
        run_compare(0, 4'b0100, 4'b0011, 3, 3'b100, "t3_gt_bit2");

        // ---------------- full-scan instance ----------------
        run_compare(1, 4'b1000, 4'b0000, 5, 3'b100, "t3_full_gt");
        // first difference at bit 2 says greater; later bits would say smaller
        run_compare(1, 4'b0100, 4'b0011, 5, 3'b100, "t3_full_sticky");
        run_compare(1, 4'b1111, 4'b1111, 5, 3'b010, "t3_full_eq");

        // ---------------- start ignored while busy ----------------
        A = 4'h0; B = 4'h0; start_ee = 1'b1;          // cycle 0
        step(); start_ee = 1'b0;                      // cycle 1
        step();                                       // cycle 2
        check("t4_busy_c2", 32'(busy_ee), 32'd1);
        A = 4'hF; B = 4'h0; start_ee = 1'b1;
        step(); start_ee = 1'b0;                      // cycle 3
        ndone = 0;
        for (int k = 3; k <= 10; k++) begin
            o = obs(0);
            if (o[3]) ndone++;
            check($sformatf("t4_done_c%0d", k), 32'(o[3]), 32'(k == 5));
            if (k >= 5) check($sformatf("t4_flags_c%0d", k), 32'(o[2:0]), 32'h2);
            step();
        end
        check("t4_done_count", 32'(ndone), 32'd1);
        prev_flags[0] = 3'b010;
        $display("txn t4 start-while-busy ignored, done_count=%0d", ndone);

        // ---------------- back-to-back ----------------
        A = 4'h8; B = 4'h0; start_ee = 1'b1;          // cycle 0
        step(); start_ee = 1'b0;                      // cycle 1
        step();                                       // cycle 2
        check("t5_done_c2",  32'(done_ee), 32'd1);
        check("t5_flags_c2", 32'(obs(0) & 5'h7), 32'h4);
        A = 4'h0; B = 4'h8; start_ee = 1'b1;
        step(); start_ee = 1'b0;                      // cycle 3
        check("t5_busy_c3",  32'(busy_ee), 32'd1);
        check("t5_done_c3",  32'(done_ee), 32'd0);
        check("t5_flags_c3", 32'(obs(0) & 5'h7), 32'h4);
        step();                                       // cycle 4
        check("t5_done_c4",  32'(done_ee), 32'd1);
        check("t5_flags_c4", 32'(obs(0) & 5'h7), 32'h1);
        step();                                       // cycle 5
        check("t5_idle_c5",  32'(obs(0)), 32'h1);
        $display("txn t5 back-to-back GREATER then SMALLER");

        // ---------------- reset mid-SHIFT ----------------
        A = 4'h3; B = 4'h3; start_ee = 1'b1;          // cycle 0
        step(); start_ee = 1'b0;                      // cycle 1
        step(); rst = 1'b1;                           // cycle 2
        step(); rst = 1'b0;                           // cycle 3
        for (int k = 3; k <= 8; k++) begin
            check($sformatf("t6_out_c%0d", k), 32'(obs(0)), 32'h0);
            step();
        end
        prev_flags[0] = 3'b000;
        prev_flags[1] = 3'b000;
        $display("txn t6 reset mid-shift drops compare");

        // ---------------- reset together with start ----------------
        A = 4'h8; B = 4'h0; start_ee = 1'b1; rst = 1'b1;
        step(); start_ee = 1'b0; rst = 1'b0;
        check("t7_rst_start_c1", 32'(obs(0)), 32'h0);
        step();
        check("t7_rst_start_c2", 32'(obs(0)), 32'h0);
        $display("txn t7 reset wins over start");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
